// File: rtl/spi_irq_pkg.sv
// Shared definitions for the SPI IRQ scheduler: FSM state encoding,
// id-width helper and the default holdoff length.
package spi_irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEFAULT_HOLDOFF = 4095;

  // Width of a source index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_irq_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of elig at or
// above ptr, wrapping past N-1 back to 0.
module spi_irq_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W:0]     sum;

  // Rotate so bit 0 is the pointer position, take the lowest set bit, map back.
  always_comb begin
    dbl = {elig, elig} >> ptr;
    rot = dbl[N-1:0];
    any = |rot;
    sum = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) sum = {1'b0, ptr} + (W+1)'(k);
    end
    if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/spi_irq_scheduler.sv
// SPI IRQ scheduler: latches rising edges on N_SRC IRQ lines, offers them one
// at a time (round-robin) to the SPI engine, and enforces a quiet period of
// HOLDOFF cycles after each completed transaction.
// Optional feature macro: SPI_IRQ_MASK_EN adds a mask port; masked sources
// still latch pending but are skipped by the picker.
//
// state | meaning
// IDLE  | nothing offered; picks the next eligible pending source
// OFFER | req_valid high, req_id held until req_ready
// WAIT  | engine owns the transaction; waiting for done
// HOLD  | quiet period after done, HOLDOFF cycles long
module spi_irq_scheduler
  import spi_irq_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int HOLDOFF = DEFAULT_HOLDOFF,
  parameter int TW      = 12,
  localparam int ID_W   = id_w(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  output logic             req_valid,
  output logic [ID_W-1:0]  req_id,
  input  logic             req_ready,
  input  logic             done,
  output logic             busy,
  output logic [N_SRC-1:0] pend
`ifdef SPI_IRQ_MASK_EN
  ,
  input  logic [N_SRC-1:0] mask
`endif
);

  localparam logic [TW-1:0] HOLD_LAST = (HOLDOFF > 0) ? TW'(HOLDOFF - 1) : TW'(0);

  state_t           state, state_nxt;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic             hs;
  logic [TW-1:0]    timer;

  assign hs  = (state == OFFER) && req_ready;
  assign clr = hs ? ({{(N_SRC-1){1'b0}}, 1'b1} << req_id) : '0;

`ifdef SPI_IRQ_MASK_EN
  assign elig = pend & ~mask;
`else
  assign elig = pend;
`endif

  spi_irq_rr_pick #(
    .N (N_SRC),
    .W (ID_W)
  ) u_pick (
    .elig (elig),
    .ptr  (rr_ptr),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Edge detect and pending latch; a new edge beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
      pend <= '0;
    end else begin
      prev <= src_irq;
      pend <= (pend & ~clr) | (src_irq & ~prev);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; done outside WAIT is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any)  state_nxt = OFFER;
      OFFER:   if (req_ready) state_nxt = WAIT;
      WAIT:    if (done)      state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
      HOLD:    if (timer == HOLD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    req_valid = (state == OFFER);
    busy      = (state != IDLE);
  end

  // Offer id, round-robin pointer and holdoff timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_id <= '0;
      rr_ptr <= '0;
      timer  <= '0;
    end else begin
      if (state == IDLE && pick_any) req_id <= pick_idx;
      if (hs) rr_ptr <= (req_id == ID_W'(N_SRC - 1)) ? '0 : req_id + ID_W'(1);
      if (state == HOLD)             timer <= (timer == HOLD_LAST) ? '0 : timer + TW'(1);
      else if (state == WAIT && done) timer <= '0;
    end
  end

endmodule

// File: tb/tb_spi_irq_scheduler.sv
// Testbench for spi_irq_scheduler: directed scenarios plus a randomized run
// checked against a rule-level reference model.
module tb_spi_irq_scheduler;

  localparam int N    = 4;
  localparam int W    = $clog2(N);
  localparam int HOLD = 5;
  localparam int TW   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src_irq = '0;
  logic         req_ready = 1'b0;
  logic         done = 1'b0;
  logic         req_valid;
  logic [W-1:0] req_id;
  logic         busy;
  logic [N-1:0] pend;
`ifdef SPI_IRQ_MASK_EN
  logic [N-1:0] mask = '0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_irq_scheduler #(
    .N_SRC   (N),
    .HOLDOFF (HOLD),
    .TW      (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_irq   (src_irq),
    .req_valid (req_valid),
    .req_id    (req_id),
    .req_ready (req_ready),
    .done      (done),
    .busy      (busy),
    .pend      (pend)
`ifdef SPI_IRQ_MASK_EN
    ,
    .mask      (mask)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; src_irq = '0; req_ready = 1'b0; done = 1'b0;
`ifdef SPI_IRQ_MASK_EN
    mask = '0;
`endif
    tick(); tick();
    rst = 1'b0;
  endtask

  // First pending source at or after start, wrapping.
  function automatic logic [W-1:0] rr_ref(input logic [N-1:0] p, input int start);
    logic [W-1:0] j;
    for (int k = 0; k < N; k++) begin
      j = W'((start + k) % N);
      if (p[j]) return j;
    end
    return '0;
  endfunction

  task automatic test_reset();
    rst = 1'b1; src_irq = 4'b1000; req_ready = 1'b0; done = 1'b0;
    tick(); tick();
    checks++;
    if (req_valid !== 1'b0 || busy !== 1'b0 || pend !== 4'b0000 || req_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b pend=%b id=%0d, required all zero",
               req_valid, busy, pend, req_id);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pend !== 4'b1000 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_edge: pend=%b valid=%b, required pend=1000 valid=0", pend, req_valid);
    end
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd3) begin
      errors++;
      $display("FAIL reset_release_offer: valid=%b id=%0d, required valid=1 id=3", req_valid, req_id);
    end
    req_ready = 1'b1; src_irq = '0; tick();
    req_ready = 1'b0; done = 1'b1; tick();
    done = 1'b0;
    repeat (HOLD + 2) tick();
  endtask

  task automatic test_single();
    int n;
    do_reset();
    src_irq[2] = 1'b1; tick(); src_irq[2] = 1'b0;
    checks++;
    if (pend !== 4'b0100 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: pend=%b valid=%b, required pend=0100 valid=0", pend, req_valid);
    end
    tick();
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd2) begin
      errors++;
      $display("FAIL single_offer: valid=%b id=%0d, required valid=1 id=2", req_valid, req_id);
    end
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || pend !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_accept: valid=%b pend=%b busy=%b, required 0 0000 1", req_valid, pend, busy);
    end
    done = 1'b1; tick(); done = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < HOLD + 10) begin n++; tick(); end
    checks++;
    if (n != HOLD) begin
      errors++;
      $display("FAIL single_holdoff: busy for %0d cycles after done, required %0d", n, HOLD);
    end
  endtask

  task automatic test_rr();
    int n, t0, last_done, exp_cycle;
    logic [W-1:0] exp_ids [3];
    exp_ids = '{2'd0, 2'd1, 2'd3};
    do_reset();
    src_irq = 4'b1011; t0 = cyc; tick(); src_irq = '0;
    last_done = 0;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (req_valid !== 1'b1 && n < HOLD + 20) begin tick(); n++; end
      exp_cycle = (g == 0) ? t0 + 2 : last_done + HOLD + 2;
      checks++;
      if (cyc != exp_cycle) begin
        errors++;
        $display("FAIL rr_timing[%0d]: offer at cycle %0d, required %0d", g, cyc, exp_cycle);
      end
      checks++;
      if (req_id !== exp_ids[g]) begin
        errors++;
        $display("FAIL rr_order[%0d]: id=%0d, required %0d", g, req_id, exp_ids[g]);
      end
      req_ready = 1'b1; tick(); req_ready = 1'b0;
      done = 1'b1; last_done = cyc; tick(); done = 1'b0;
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] id;
    id = W'($urandom_range(0, N - 1));
    do_reset();
    src_irq = '0; src_irq[id] = 1'b1; tick(); src_irq = '0; tick();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (req_valid !== 1'b1 || req_id !== id) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%b id=%0d, required valid=1 id=%0d", k, req_valid, req_id, id);
      end
      tick();
    end
    checks++;
    if (req_valid !== 1'b1 || req_id !== id) begin
      errors++;
      $display("FAIL stall_cycle11: valid=%b id=%0d, required valid=1 id=%0d", req_valid, req_id, id);
    end
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || pend !== 4'b0000) begin
      errors++;
      $display("FAIL stall_accept: valid=%b pend=%b, required valid=0 pend=0000", req_valid, pend);
    end
    done = 1'b1; tick(); done = 1'b0;
    repeat (HOLD + 1) tick();
  endtask

  task automatic test_set_wins();
    int n, d;
    do_reset();
    src_irq[1] = 1'b1; tick(); src_irq[1] = 1'b0; tick();
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd1) begin
      errors++;
      $display("FAIL setwins_offer: valid=%b id=%0d, required valid=1 id=1", req_valid, req_id);
    end
    req_ready = 1'b1; src_irq[1] = 1'b1; tick();
    req_ready = 1'b0; src_irq[1] = 1'b0;
    checks++;
    if (pend[1] !== 1'b1 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL setwins_pend: pend=%b valid=%b, required pend[1]=1 valid=0", pend, req_valid);
    end
    done = 1'b1; d = cyc; tick(); done = 1'b0;
    n = 0;
    while (req_valid !== 1'b1 && n < HOLD + 20) begin tick(); n++; end
    checks++;
    if (cyc != d + HOLD + 2 || req_id !== 2'd1) begin
      errors++;
      $display("FAIL setwins_regrant: offer at cycle %0d id=%0d, required cycle %0d id=1",
               cyc, req_id, d + HOLD + 2);
    end
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    checks++;
    if (pend !== 4'b0000) begin
      errors++;
      $display("FAIL setwins_clear: pend=%b, required 0000", pend);
    end
    done = 1'b1; tick(); done = 1'b0;
    repeat (HOLD + 1) tick();
  endtask

  task automatic test_rst_hold();
    int bad;
    do_reset();
    src_irq[0] = 1'b1; tick(); src_irq[0] = 1'b0; tick();
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    src_irq[2] = 1'b1; tick(); src_irq[2] = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || pend !== 4'b0100) begin
      errors++;
      $display("FAIL rsthold_inhold: busy=%b pend=%b, required busy=1 pend=0100", busy, pend);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (req_valid !== 1'b0 || busy !== 1'b0 || pend !== 4'b0000 || req_id !== 2'd0) begin
      errors++;
      $display("FAIL rsthold_cleared: valid=%b busy=%b pend=%b id=%0d, required all zero",
               req_valid, busy, pend, req_id);
    end
    bad = 0;
    repeat (HOLD + 4) begin
      if (req_valid !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rsthold_quiet: %0d cycles active after reset, required 0", bad);
    end
    src_irq = 4'b1001; tick(); src_irq = '0; tick();
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd0) begin
      errors++;
      $display("FAIL rsthold_ptr: valid=%b id=%0d, required valid=1 id=0", req_valid, req_id);
    end
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    repeat (HOLD + 1) tick();
  endtask

`ifdef SPI_IRQ_MASK_EN
  task automatic test_mask();
    int bad;
    do_reset();
    mask = 4'b0001;
    src_irq = 4'b0101; tick(); src_irq = '0; tick();
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd2) begin
      errors++;
      $display("FAIL mask_skip: valid=%b id=%0d, required valid=1 id=2", req_valid, req_id);
    end
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    bad = 0;
    repeat (HOLD + 4) begin
      if (req_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || pend !== 4'b0001) begin
      errors++;
      $display("FAIL mask_hold: %0d offers while masked, pend=%b, required 0 offers pend=0001", bad, pend);
    end
    mask = '0; tick();
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd0) begin
      errors++;
      $display("FAIL mask_unmask: valid=%b id=%0d, required valid=1 id=0", req_valid, req_id);
    end
    mask = 4'b0001; tick();
    checks++;
    if (req_valid !== 1'b1 || req_id !== 2'd0) begin
      errors++;
      $display("FAIL mask_norevoke: valid=%b id=%0d, required valid=1 id=0", req_valid, req_id);
    end
    mask = '0; req_ready = 1'b1; tick(); req_ready = 1'b0;
    done = 1'b1; tick(); done = 1'b0;
    repeat (HOLD + 1) tick();
  endtask
`endif

  // Randomized traffic. The model tracks pending bits, the rotation start,
  // whether an offer or transaction is outstanding, and the first cycle an
  // offer may appear after the last done (done + HOLD + 2).
  task automatic test_random();
    logic [N-1:0] m_pend, m_pend_prev, last_src, e, clr;
    logic [W-1:0] offer_id;
    int ptr, quiet_from, c;
    bit offering, active, exp_busy, rdy, dn;
    do_reset();
    m_pend = '0; m_pend_prev = '0; last_src = '0; offer_id = '0;
    ptr = 0; quiet_from = 0; offering = 0; active = 0;
    for (int i = 0; i < 800; i++) begin
      c = cyc;
      if (!offering && !active && c >= quiet_from && m_pend_prev != '0) begin
        offering = 1;
        offer_id = rr_ref(m_pend_prev, ptr);
      end
      exp_busy = offering || active || (c < quiet_from - 1);
      checks++;
      if (req_valid !== offering) begin
        errors++;
        $display("FAIL rand_valid@%0d: valid=%b, required %b", c, req_valid, offering);
      end
      if (offering) begin
        checks++;
        if (req_id !== offer_id) begin
          errors++;
          $display("FAIL rand_id@%0d: id=%0d, required %0d", c, req_id, offer_id);
        end
      end
      checks++;
      if (pend !== m_pend) begin
        errors++;
        $display("FAIL rand_pend@%0d: pend=%b, required %b", c, pend, m_pend);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL rand_busy@%0d: busy=%b, required %b", c, busy, exp_busy);
      end

      e   = ($urandom_range(0, 3) == 0) ? (N'($urandom) & ~last_src) : '0;
      rdy = ($urandom_range(0, 2) == 0);
      dn  = 0;
      if (active)                      dn = ($urandom_range(0, 2) == 0);
      else if (c >= quiet_from - 1)    dn = ($urandom_range(0, 5) == 0);
      src_irq = e; req_ready = rdy; done = dn; last_src = e;

      clr = '0;
      if (offering && rdy) begin
        clr[offer_id] = 1'b1;
        ptr = (int'(offer_id) + 1) % N;
        offering = 0;
        active = 1;
      end else if (active && dn) begin
        active = 0;
        quiet_from = c + HOLD + 2;
      end
      m_pend_prev = m_pend;
      m_pend = (m_pend & ~clr) | e;
      tick();
    end
    src_irq = '0; req_ready = 1'b0; done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_set_wins();
    test_rst_hold();
`ifdef SPI_IRQ_MASK_EN
    test_mask();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
